gpio_sw_reader: RTL and testbench
=================================

Name: gpio_sw_reader

Overview:
Memory-mapped input peripheral that lets the core read the board switches (sw_i). It synchronises and debounces each switch bit, keeps sticky per-bit change flags, and raises a level interrupt. It sits on the core data bus beside the LED output register, as the read-side counterpart of the LED driver.

Parameters:
WIDTH, 4, number of switch inputs (1..32)
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a new level (>=1)

Ports:
clk_sys_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
sw_i  input  WIDTH  asynchronous switch inputs
addr_i  input  4  byte offset within block; bits [1:0] ignored
re_i  input  1  read strobe, one cycle per access
we_i  input  1  write strobe, one cycle per access
wdata_i  input  32  write data
rdata_o  output  32  read data, registered
irq_o  output  1  interrupt request, level, registered

Behaviour:
- Reset (rst_i high at an edge): sync flops, debounced state, counters, EDGE, IRQ_EN, rdata_o and irq_o all 0. Reset mid-debounce discards the count.
- Synchroniser: two flops per bit, s1 <= sw_i, s2 <= s1. No combinational path from sw_i to any output.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - s2 == deb: cnt <= 0.
  - s2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0, EDGE[i] <= 1.
  - s2 != deb otherwise: cnt <= cnt+1.
  - Latency: sw_i stable before edge k gives s2 at edge k+1 and deb at edge k+1+DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES cycles at s2 are rejected and produce no EDGE.
- Register map (word aligned):
  - 0x0 DATA: RO, {0, deb}.
  - 0x4 EDGE: sticky change flags, W1C. Writing 1 clears the bit, writing 0 has no effect.
  - 0x8 IRQ_EN: RW, bits [WIDTH-1:0]. Upper bits read 0.
  - 0xC RAW: RO, {0, s2}.
- Reads: rdata_o is valid the cycle after re_i and returns the register value sampled at that edge. rdata_o holds its value when re_i is low. Unmapped offsets are not possible with 4-bit addr_i.
- Writes: take effect at the edge where we_i is high. Writes to DATA and RAW are ignored.
- re_i and we_i in the same cycle to the same register: read returns the pre-write value.
- Simultaneous W1C clear and a new debounced change on the same bit: set wins, EDGE[i] stays 1.
- irq_o <= |(EDGE & IRQ_EN), so it rises one cycle after the EDGE set or IRQ_EN write that causes it.
- Switches already high out of reset are treated as a change: deb follows after the normal latency and EDGE sets. Software clears EDGE after boot.

Test Plan:
- Reset then idle, sw_i=0: every register reads 0x0 and irq_o=0 for 20 cycles.
- sw_i 0 -> 4'b0101 before edge k: RAW=0x5 readable from edge k+1. DATA=0x5 and EDGE=0x5 at edge k+5. irq_o stays 0 because IRQ_EN=0.
- IRQ_EN=0x1, then sw_i bit0 rises: irq_o rises one cycle after EDGE[0] sets. Write 0x1 to EDGE: EDGE=0x0, and irq_o falls the cycle after that.
- Glitch: sw_i bit2 high for 3 cycles then low, with DEBOUNCE_CYCLES=4: DATA and EDGE remain 0x0. Repeat with 4 stable cycles: DATA bit2=1.
- Write 0x4 to EDGE on the same edge bit2's debounced value toggles: EDGE bit2 reads 1 afterwards.
- Assert rst_i with cnt=2 and EDGE=0xF: the next cycle every register reads 0 and irq_o=0. Then a fresh 4-cycle debounce is required.

Source files
------------

// File: rtl/gpio_sw_reader.sv
// Switch input peripheral: a two-flop synchroniser and a debouncer per bit, sticky W1C change
// flags, an interrupt enable mask and a registered level interrupt, all on a small register map.
module gpio_sw_reader #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_sys_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  input  logic [3:0]       addr_i,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;
  logic             edge_wr, irq_en_wr;
  logic             unused_bits;

  assign unused_bits = ^{addr_i[1:0], wdata_i};

  // Per-bit debounce: a level is accepted once s2 has differed for DEBOUNCE_CYCLES samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    chg   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
        chg[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign edge_wr   = we_i && (addr_i[3:2] == 2'd1);
  assign irq_en_wr = we_i && (addr_i[3:2] == 2'd2);

  // A new change on the same edge as a W1C clear keeps its flag set.
  always_comb begin
    edge_d = edge_q;
    if (edge_wr) begin
      edge_d = edge_q & ~wdata_i[WIDTH-1:0];
    end
    edge_d   = edge_d | chg;
    irq_en_d = irq_en_wr ? wdata_i[WIDTH-1:0] : irq_en_q;
  end

  // Reads see the pre-write register values.
  always_comb begin
    rdata_d = '0;
    unique case (addr_i[3:2])
      2'd0: rdata_d = 32'(deb_q);
      2'd1: rdata_d = 32'(edge_q);
      2'd2: rdata_d = 32'(irq_en_q);
      2'd3: rdata_d = 32'(s2_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      cnt_q    <= '{default: '0};
      edge_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      if (re_i) begin
        rdata_q <= rdata_d;
      end
      irq_q    <= |(edge_q & irq_en_q);
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_gpio_sw_reader.sv
// Directed bench for gpio_sw_reader: exact-cycle checks of debounce latency, W1C, IRQ and reset.
module tb_gpio_sw_reader;

  localparam logic [3:0] AData  = 4'h0;
  localparam logic [3:0] AEdge  = 4'h4;
  localparam logic [3:0] AIrqEn = 4'h8;
  localparam logic [3:0] ARaw   = 4'hC;

  logic        clk_sys_i = 1'b0;
  logic        rst_i     = 1'b1;
  logic [3:0]  sw_i      = '0;
  logic [3:0]  addr_i    = '0;
  logic        re_i      = 1'b0;
  logic        we_i      = 1'b0;
  logic [31:0] wdata_i   = '0;
  logic [31:0] rdata_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  gpio_sw_reader #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_sys_i(clk_sys_i),
    .rst_i    (rst_i),
    .sw_i     (sw_i),
    .addr_i   (addr_i),
    .re_i     (re_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .irq_o    (irq_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  // Advance past one rising edge; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr_i = a;
    re_i   = 1'b1;
    step();
    re_i = 1'b0;
    d    = rdata_o;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    step();
    we_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    checks++;
    if (rdata_o !== 32'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: rdata=%h irq=%b want 0/0", rdata_o, irq_o);
    end
    for (int i = 0; i < 20; i++) begin
      bus_read(4'(i * 4), d);
      checks++;
      if (d !== 32'h0 || irq_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_read[%0d]: rdata=%h irq=%b want 0/0", i, d, irq_o);
      end
    end
  endtask

  task automatic test_debounce();
    logic [3:0]  a   [8] = '{ARaw, ARaw, ARaw, AData, AData, AData, AData, AEdge};
    logic [31:0] exp [8] = '{32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h5, 32'h5};
    logic [31:0] d;
    sw_i = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      bus_read(a[i], d);
      checks++;
      if (d !== exp[i] || irq_o !== 1'b0) begin
        errors++;
        $display("FAIL debounce[%0d]: rdata=%h irq=%b want %h/0", i, d, irq_o, exp[i]);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    sw_i = 4'b0100;
    repeat (10) step();
    bus_write(AEdge, 32'hF);
    bus_write(AIrqEn, 32'h1);
    step();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle: irq=%b want 0", irq_o);
    end
    sw_i = 4'b0101;
    repeat (6) step();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_on_edge_set: irq=%b want 0", irq_o);
    end
    step();
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b want 1", irq_o);
    end
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL irq_edge_read: rdata=%h want 1", d);
    end
    bus_write(AEdge, 32'h1);
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold_on_clear: irq=%b want 1", irq_o);
    end
    step();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall: irq=%b want 0", irq_o);
    end
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL edge_cleared: rdata=%h want 0", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic [31:0] exp [3] = '{32'h1, 32'h1, 32'h5};
    sw_i = 4'b0001;
    repeat (10) step();
    bus_write(AEdge, 32'hF);
    sw_i = 4'b0101;
    repeat (3) step();
    sw_i = 4'b0001;
    repeat (10) step();
    bus_read(AData, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL glitch_data: rdata=%h want 1", d);
    end
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL glitch_edge: rdata=%h want 0", d);
    end
    sw_i = 4'b0101;
    repeat (4) step();
    sw_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      bus_read(AData, d);
      checks++;
      if (d !== exp[i]) begin
        errors++;
        $display("FAIL pulse4_data[%0d]: rdata=%h want %h", i, d, exp[i]);
      end
    end
    repeat (10) step();
    bus_read(AData, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL pulse4_fall: rdata=%h want 1", d);
    end
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL pulse4_edge: rdata=%h want 4", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(AEdge, 32'hF);
    sw_i = 4'b0101;
    repeat (5) step();
    bus_write(AEdge, 32'h4);  // lands on the edge where deb bit2 rises
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL set_beats_clear: rdata=%h want 4", d);
    end
    bus_write(AEdge, 32'h4);
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL w1c_plain: rdata=%h want 0", d);
    end
    addr_i  = AIrqEn;
    wdata_i = 32'h3;
    re_i    = 1'b1;
    we_i    = 1'b1;
    step();
    re_i = 1'b0;
    we_i = 1'b0;
    checks++;
    if (rdata_o !== 32'h1) begin
      errors++;
      $display("FAIL rw_same_cycle: rdata=%h want 1", rdata_o);
    end
    bus_read(AIrqEn, d);
    checks++;
    if (d !== 32'h3) begin
      errors++;
      $display("FAIL irq_en_rw: rdata=%h want 3", d);
    end
    bus_write(AIrqEn, 32'hFFFF_FFF0);
    bus_read(AIrqEn, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL irq_en_upper: rdata=%h want 0", d);
    end
    bus_write(AData, 32'hF);
    bus_write(ARaw, 32'hF);
    bus_read(AData, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL data_ro: rdata=%h want 5", d);
    end
    bus_read(ARaw, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL raw_ro: rdata=%h want 5", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  a   [7] = '{ARaw, AData, AEdge, AIrqEn, AData, AData, AData};
    logic [31:0] exp [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5};
    logic [31:0] d;
    sw_i = 4'b1010;
    repeat (10) step();
    bus_write(AIrqEn, 32'hF);
    bus_read(AEdge, d);
    checks++;
    if (d !== 32'hF || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: rdata=%h irq=%b want f/1", d, irq_o);
    end
    sw_i = 4'b0101;
    repeat (4) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if (rdata_o !== 32'h0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: rdata=%h irq=%b want 0/0", rdata_o, irq_o);
    end
    for (int i = 0; i < 7; i++) begin
      bus_read(a[i], d);
      checks++;
      if (d !== exp[i] || irq_o !== 1'b0) begin
        errors++;
        $display("FAIL after_reset[%0d]: rdata=%h irq=%b want %h/0", i, d, irq_o, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_irq();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
